// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack fetch toward instruction memory, a small
// PC-tagged prefetch FIFO, and a pre-split head entry presented to ID.
module instr_fetch #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [31:0]         imem_rdata_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                stall_i,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] instr_pc_o,
    output logic [6:0]          opcode_o,
    output logic [2:0]          funct3_o,
    output logic [6:0]          funct7_o
);

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic [PC_WIDTH-1:0] r_mem_pc    [FIFO_DEPTH];
    logic [31:0]         r_mem_instr [FIFO_DEPTH];

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;
    logic [FIFO_DEPTH-1:0] w_we;

    // Request only when there is room; redirect and reset suppress it so a
    // same-cycle ack can never push a stale word.
    assign w_full      = (r_count == FULL_CNT);
    assign imem_req_o  = !rst_i && !redirect_i && !w_full;
    assign imem_addr_o = r_fetch_pc;
    assign w_push      = imem_req_o && imem_ack_i;

    // Valid is gated by reset so the outputs are quiet during the reset cycle.
    assign w_valid = (r_count != '0) && !rst_i;
    assign w_pop   = w_valid && !stall_i && !redirect_i;

    // Per-slot write enables decoded from the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    // Occupancy update: simultaneous push and pop keeps the count unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Fetch PC, pointers and count; reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Storage: returned word tagged with the address it was fetched from.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_we[i]) begin
                r_mem_pc[i]    <= r_fetch_pc;
                r_mem_instr[i] <= imem_rdata_i;
            end
        end
    end

    // Head entry is forced to zero whenever nothing valid is presented.
    assign instr_o    = w_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
    assign instr_pc_o = w_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign opcode_o   = instr_o[6:0];
    assign funct3_o   = instr_o[14:12];
    assign funct7_o   = instr_o[31:25];
    assign instr_valid_o = w_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the fetch stage.
module tb_instr_fetch;

    localparam int          PC_WIDTH   = 32;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [6:0]  opcode_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;

    always #5 clk = ~clk;

    instr_fetch #(
        .PC_WIDTH   (PC_WIDTH),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .opcode_o      (opcode_o),
        .funct3_o      (funct3_o),
        .funct7_o      (funct7_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: the fetch address and an ordered queue of buffered words.
    ent_t        m_q[$];
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_errors = 0;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h200) return 32'h40D2D293;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic rst, input logic ack, input logic stall,
                        input logic redir, input logic [31:0] rpc);
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] rdata;
        ent_t        head;
        ent_t        e;
        @(negedge clk);
        rst_i         = rst;
        imem_ack_i    = ack;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        rdata         = mem_word(m_pc);
        imem_rdata_i  = rdata;
        #1;
        exp_req   = !rst && !redir && (m_q.size() < FIFO_DEPTH);
        exp_valid = !rst && (m_q.size() != 0);
        head      = exp_valid ? m_q[0] : '0;
        check_eq("req",    32'(imem_req_o),    32'(exp_req));
        check_eq("addr",   imem_addr_o,        m_pc);
        check_eq("valid",  32'(instr_valid_o), 32'(exp_valid));
        check_eq("instr",  instr_o,            head.instr);
        check_eq("pc",     instr_pc_o,         head.pc);
        check_eq("opcode", 32'(opcode_o),      32'(head.instr[6:0]));
        check_eq("funct3", 32'(funct3_o),      32'(head.instr[14:12]));
        check_eq("funct7", 32'(funct7_o),      32'(head.instr[31:25]));
        if (exp_valid && head.pc == 32'h200) begin
            check_eq("opcode_0x200", 32'(opcode_o), 32'h13);
            check_eq("funct3_0x200", 32'(funct3_o), 32'h5);
            check_eq("funct7_0x200", 32'(funct7_o), 32'h20);
        end
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC;
            m_q.delete();
        end else if (redir) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_valid && !stall) begin
                $display("instr pc=0x%08h word=0x%08h", head.pc, head.instr);
                void'(m_q.pop_front());
            end
            if (exp_req && ack) begin
                e.pc    = m_pc;
                e.instr = rdata;
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; imem_ack_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'h0; imem_rdata_i = 32'h0;
        m_pc = RESET_PC;
        @(posedge clk);
        step(1, 1, 0, 0, 0);

        // Streaming from reset: pcs 0x0, 0x4, 0x8 back to back.
        repeat (5) step(0, 1, 0, 0, 0);

        // Stall from an empty FIFO, then release.
        step(0, 0, 0, 1, 32'h0);
        repeat (4) step(0, 1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0);

        // Fill with 0x8/0xC, then redirect to 0x100 with ack asserted.
        step(0, 0, 0, 1, 32'h8);
        repeat (3) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h100);
        repeat (3) step(0, 1, 0, 0, 0);

        // Wait states at 0x10.
        step(0, 0, 0, 1, 32'h10);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0);

        // Unaligned redirect, then reset together with redirect.
        step(0, 1, 0, 1, 32'h103);
        repeat (2) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'h300);
        repeat (2) step(0, 1, 0, 0, 0);

        // Field split of a known word, and back-to-back redirects (last wins).
        step(0, 1, 0, 1, 32'h500);
        step(0, 1, 0, 1, 32'h200);
        repeat (3) step(0, 1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);

        // Fetch address wraps past the top of the address space.
        step(0, 1, 0, 1, 32'hFFFF_FFF8);
        repeat (5) step(0, 1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 5,
                 rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sources the instruction stream consumed by the ID-stage decoder. It drives a req/ack handshake toward instruction memory, buffers returned words in a small prefetch FIFO tagged with their PC, and presents the head entry plus pre-split opcode/funct3/funct7 fields to ID. Branch redirects flush the buffer and restart fetch; ID stalls hold the head entry.

Parameters:
PC_WIDTH, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, prefetch entries (power of two, >=2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
imem_req_o  out  1  fetch request
imem_addr_o  out  PC_WIDTH  fetch address, word aligned
imem_ack_i  in  1  memory accepts request; rdata valid same cycle
imem_rdata_i  in  32  instruction word
redirect_i  in  1  branch taken (ID or EX); flush and restart
redirect_pc_i  in  PC_WIDTH  restart address
stall_i  in  1  ID cannot accept; hold head entry
instr_valid_o  out  1  head entry valid
instr_o  out  32  head instruction
instr_pc_o  out  PC_WIDTH  PC of head instruction
opcode_o  out  7  instr_o[6:0]
funct3_o  out  3  instr_o[14:12]
funct7_o  out  7  instr_o[31:25]

Behaviour:
- State: fetch_pc register; FIFO of {pc, instr}, with read pointer, write pointer and count (0..FIFO_DEPTH).
- Reset (sync, any cycle, including mid-transfer): fetch_pc=RESET_PC, count=0, pointers=0. Outputs in and after the reset cycle: imem_req_o=0, instr_valid_o=0, instr_o/instr_pc_o/fields=0. Reset overrides redirect, ack and stall.
- imem_req_o = !rst_i & !redirect_i & (count < FIFO_DEPTH). imem_addr_o = fetch_pc.
- Transfer = imem_req_o & imem_ack_i: push {fetch_pc, imem_rdata_i} at the write pointer; fetch_pc <= fetch_pc + 4 (wraps modulo 2^PC_WIDTH).
- Without ack, fetch_pc and imem_addr_o hold stable while imem_req_o stays high. Memory may ack in the first request cycle (zero wait) or after N wait cycles.
- instr_valid_o = (count != 0). Head fields are taken from the read-pointer entry. When empty, all data outputs are 0.
- Pop = instr_valid_o & !stall_i & !redirect_i: advance the read pointer. Simultaneous push and pop leaves count unchanged. No push occurs when full, so full plus pop gives count-1 next cycle and request resumes that cycle.
- Redirect (redirect_i=1, not in reset): count<=0 and pointers<=0. fetch_pc <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00}, so the low two bits are forced to zero. imem_req_o=0 in this cycle, so any ack in the same cycle is ignored and nothing is pushed. Redirect overrides stall and pop. Next cycle: instr_valid_o=0 and imem_addr_o = redirect target.
- Back-to-back redirects: the last one wins.
- Latency: with zero-wait ack and an empty FIFO, an instruction requested in cycle T appears at instr_valid_o in T+1.
- Throughput: one instruction per cycle sustained with ack=1 and stall=0.
- Pointers wrap modulo FIFO_DEPTH.
- The block has no combinational path from imem_rdata_i to its outputs.

Test Plan:
1. Release reset with ack=1 and stall=0. Required: req=1 and addr=0x0 in the first cycle after reset. instr_pc_o then reads 0x0, 0x4, 0x8 on consecutive cycles, and instr_o equals the rdata returned for each address.
2. Hold stall=1 with ack=1 from an empty FIFO. Required: count reaches 2 and req drops. instr_pc_o stays at 0x0 for the whole stall. After stall=0, pcs 0x0, 0x4, 0x8 appear with no gap or duplicate.
3. With the FIFO full (pcs 0x8, 0xC), pulse redirect=1 with redirect_pc=0x100 and ack=1 in that cycle. Required: req=0 in the redirect cycle. Next cycle: instr_valid_o=0, addr=0x100. The first valid instruction afterwards has pc 0x100.
4. Set ack low for 3 cycles while at addr 0x10. Required: req=1 and addr=0x10 stable for all 3 cycles and instr_valid_o=0 (FIFO empty). On ack, the instruction appears next cycle with pc 0x10.
5. Redirect with redirect_pc=0x103. Required: next addr=0x100. Assert rst_i mid-stream together with redirect=1. Required: next cycle addr=RESET_PC and instr_valid_o=0.
6. Return rdata=0x40D2D293. Required: opcode_o=0x13, funct3_o=0x5, funct7_o=0x20 while that entry is at the head.
